// File: rtl/q2_xshift_port_if.sv
// Host-side handshake of the X-chain serial port: start/tx_data in, busy/done/rx_data out.
// The port itself uses the slave modport; whoever requests transfers uses master.
interface q2_xshift_port_if #(
    parameter int unsigned WIDTH = 12
);
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;

    modport master (
        output start,
        output tx_data,
        input  busy,
        input  done,
        input  rx_data
    );

    modport slave (
        input  start,
        input  tx_data,
        output busy,
        output done,
        output rx_data
    );
endinterface

// File: rtl/q2_xshift_port.sv
// Serial I/O engine at the far end of the bit-slice X chain: shifts a new word into X
// MSB first while reassembling the old X contents from the open-drain io line.
module q2_xshift_port #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned STROBE_LEN = 1
) (
    input  logic              clk,
    input  logic              nrst,
    q2_xshift_port_if.slave   host,
    input  logic              io_in,
    output logic              xin_shift,
    output logic              wrx,
    output logic              nxin
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] SAMPLE = 3'd2;
    localparam logic [2:0] STROBE = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam int unsigned TMAX = (SETTLE > STROBE_LEN) ? SETTLE : STROBE_LEN;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned CW   = $clog2(WIDTH + 1);

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    tmr_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] tx_sr_q, rx_sr_q, rx_data_q;
    logic             busy_q, done_q, xin_shift_q, wrx_q, nxin_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (host.start) state_d = SETUP;
            SETUP:   if (tmr_q == TW'(SETTLE - 1)) state_d = SAMPLE;
            SAMPLE:  state_d = STROBE;
            STROBE:  if (tmr_q == TW'(STROBE_LEN - 1)) state_d = HOLD;
            HOLD: begin
                if (tmr_q == TW'(SETTLE - 1)) begin
                    state_d = (bit_cnt_q == CW'(WIDTH)) ? DONE : SAMPLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q exactly.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            bit_cnt_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            xin_shift_q <= 1'b0;
            wrx_q       <= 1'b0;
            nxin_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= (state_d != state_q) ? '0 : tmr_q + TW'(1);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            wrx_q       <= (state_d == STROBE);
            xin_shift_q <= (state_d == SETUP) || (state_d == SAMPLE) ||
                           (state_d == STROBE) || (state_d == HOLD);

            if (state_q == IDLE && host.start) begin
                tx_sr_q   <= host.tx_data;
                bit_cnt_q <= '0;
            end

            if (state_q == SAMPLE) begin
                rx_sr_q <= (rx_sr_q << 1) | WIDTH'(io_in);
            end

            if (state_q == STROBE && state_d == HOLD) begin
                tx_sr_q   <= tx_sr_q << 1;
                bit_cnt_q <= bit_cnt_q + CW'(1);
            end

            // nxin only moves on SAMPLE entry, never while wrx is high.
            if (state_d == SAMPLE) begin
                nxin_q <= ~tx_sr_q[WIDTH-1];
            end else if (state_d == DONE || state_d == IDLE) begin
                nxin_q <= 1'b1;
            end

            if (state_d == DONE) begin
                rx_data_q <= rx_sr_q;
            end
        end
    end

    assign host.busy    = busy_q;
    assign host.done    = done_q;
    assign host.rx_data = rx_data_q;
    assign xin_shift    = xin_shift_q;
    assign wrx          = wrx_q;
    assign nxin         = nxin_q;
endmodule

// File: tb/tb_q2_xshift_port.sv
// Scoreboard bench for q2_xshift_port: defaults (A) and WIDTH=4/SETTLE=1/STROBE_LEN=3 (B),
// each driving a behavioural model of the slice X chain.
module tb_q2_xshift_port;
    typedef struct packed {
        logic [11:0] rx;
        logic [11:0] x;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    q2_xshift_port_if #(.WIDTH(12)) hif_a ();
    q2_xshift_port_if #(.WIDTH(4))  hif_b ();

    logic        io_a, xin_shift_a, wrx_a, nxin_a;
    logic        io_b, xin_shift_b, wrx_b, nxin_b;
    logic [11:0] x_a, pre_val_a;
    logic [3:0]  x_b, pre_val_b;
    logic        pre_a = 1'b0, pre_b = 1'b0, wrx_d_a = 1'b0, wrx_d_b = 1'b0;

    q2_xshift_port u_dut_a (
        .clk       (clk),
        .nrst      (nrst),
        .host      (hif_a),
        .io_in     (io_a),
        .xin_shift (xin_shift_a),
        .wrx       (wrx_a),
        .nxin      (nxin_a)
    );

    q2_xshift_port #(.WIDTH(4), .SETTLE(1), .STROBE_LEN(3)) u_dut_b (
        .clk       (clk),
        .nrst      (nrst),
        .host      (hif_b),
        .io_in     (io_b),
        .xin_shift (xin_shift_b),
        .wrx       (wrx_b),
        .nxin      (nxin_b)
    );

    // Slice chain model: each wrx rising edge shifts X up one slice, slice 0 takes ~nxin.
    always @(negedge clk) begin
        if (pre_a) x_a <= pre_val_a;
        else if (wrx_a && !wrx_d_a) x_a <= {x_a[10:0], ~nxin_a};
        wrx_d_a <= wrx_a;
        if (pre_b) x_b <= pre_val_b;
        else if (wrx_b && !wrx_d_b) x_b <= {x_b[2:0], ~nxin_b};
        wrx_d_b <= wrx_b;
    end
    assign io_a = x_a[11];
    assign io_b = x_b[3];

    exp_t exp_a[$];
    exp_t exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor A
    int   a_rise = 0, a_pulses = 0, a_wlen = 0, a_done_cyc = 0, a_ndone = 0, a_nrise = 0;
    logic a_prev_busy = 0, a_prev_wrx = 0, a_prev_nxin = 1, a_after = 0, a_gap = 0;
    logic b2b_mode = 0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!nrst) begin
            a_pulses = 0; a_wlen = 0; a_prev_busy = 0; a_prev_wrx = 0; a_prev_nxin = 1;
            a_after = 0; a_gap = 0;
        end else begin
            if (hif_a.busy && !a_prev_busy) begin
                a_rise = cyc; a_pulses = 0; a_nrise++;
                if (a_gap) check("a idle gap", cyc - a_done_cyc, 2);
                a_gap = 0;
            end
            if (wrx_a) begin
                if (!a_prev_wrx) a_pulses++;
                a_wlen++;
                check("a nxin stable under wrx", {31'd0, nxin_a}, {31'd0, a_prev_nxin});
                check("a xin_shift under wrx", {31'd0, xin_shift_a}, 1);
            end else if (a_prev_wrx) begin
                check("a wrx width", a_wlen, 1);
                a_wlen = 0;
            end
            if (hif_a.done) begin
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a unexpected done: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = exp_a.pop_front();
                    check("a rx_data", {20'd0, hif_a.rx_data}, {20'd0, e.rx});
                    check("a chain X", {20'd0, x_a}, {20'd0, e.x});
                    check("a done cycle", cyc - a_rise + 1, 51);
                    check("a wrx pulses", a_pulses, 12);
                    check("a busy in done", {31'd0, hif_a.busy}, 1);
                end
                a_done_cyc = cyc; a_after = 1; a_gap = b2b_mode; a_ndone++;
            end else if (a_after) begin
                check("a busy after done", {31'd0, hif_a.busy}, 0);
                a_after = 0;
            end
            a_prev_busy = hif_a.busy; a_prev_wrx = wrx_a; a_prev_nxin = nxin_a;
        end
    end

    // Monitor B
    int   b_rise = 0, b_pulses = 0, b_wlen = 0, b_ndone = 0;
    logic b_prev_busy = 0, b_prev_wrx = 0, b_prev_nxin = 1;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!nrst) begin
            b_pulses = 0; b_wlen = 0; b_prev_busy = 0; b_prev_wrx = 0; b_prev_nxin = 1;
        end else begin
            if (hif_b.busy && !b_prev_busy) begin
                b_rise = cyc; b_pulses = 0;
            end
            if (wrx_b) begin
                if (!b_prev_wrx) b_pulses++;
                b_wlen++;
                check("b nxin stable under wrx", {31'd0, nxin_b}, {31'd0, b_prev_nxin});
                check("b xin_shift under wrx", {31'd0, xin_shift_b}, 1);
            end else if (b_prev_wrx) begin
                check("b wrx width", b_wlen, 3);
                b_wlen = 0;
            end
            if (hif_b.done) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b unexpected done: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = exp_b.pop_front();
                    check("b rx_data", {28'd0, hif_b.rx_data}, {28'd0, e.rx[3:0]});
                    check("b chain X", {28'd0, x_b}, {28'd0, e.x[3:0]});
                    check("b done cycle", cyc - b_rise + 1, 22);
                    check("b wrx pulses", b_pulses, 4);
                end
                b_ndone++;
            end
            b_prev_busy = hif_b.busy; b_prev_wrx = wrx_b; b_prev_nxin = nxin_b;
        end
    end

    task automatic preload_a(input logic [11:0] v);
        pre_val_a = v; pre_a = 1'b1;
        repeat (2) @(negedge clk);
        pre_a = 1'b0;
    endtask

    task automatic go_a(input logic [11:0] tx, input logic [11:0] xold);
        exp_a.push_back('{rx: xold, x: tx});
        hif_a.tx_data = tx; hif_a.start = 1'b1;
        @(negedge clk);
        hif_a.start = 1'b0; hif_a.tx_data = ~tx;
    endtask

    task automatic wait_a(input int target);
        for (int i = 0; i < 400; i++) begin
            if (a_ndone >= target) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL a done timeout: got %0d dones, expected %0d", a_ndone, target);
    endtask

    initial begin
        int n;
        hif_a.start = 0; hif_a.tx_data = '0;
        hif_b.start = 0; hif_b.tx_data = '0;
        pre_val_a = '0; pre_val_b = '0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("reset busy", {31'd0, hif_a.busy}, 0);
        check("reset done", {31'd0, hif_a.done}, 0);
        check("reset xin_shift", {31'd0, xin_shift_a}, 0);
        check("reset wrx", {31'd0, wrx_a}, 0);
        check("reset nxin", {31'd0, nxin_a}, 1);
        check("reset rx_data", {20'd0, hif_a.rx_data}, 0);
        check("reset b rx_data", {28'd0, hif_b.rx_data}, 0);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (wrx_a || wrx_b) n++;
        end
        check("idle wrx cycles", n, 0);

        // Basic swap
        preload_a(12'hA5C);
        go_a(12'h3F1, 12'hA5C);
        wait_a(1);
        repeat (3) @(negedge clk);

        // Start held high: back-to-back transfers, tx change after acceptance ignored
        preload_a(12'h0C3);
        exp_a.push_back('{rx: 12'h0C3, x: 12'h3F1});
        exp_a.push_back('{rx: 12'h3F1, x: 12'h000});
        b2b_mode = 1'b1;
        n = a_nrise;
        hif_a.tx_data = 12'h3F1; hif_a.start = 1'b1;
        for (int i = 0; i < 20 && a_nrise == n; i++) @(negedge clk);
        hif_a.tx_data = 12'h000;
        for (int i = 0; i < 200 && a_nrise < n + 2; i++) @(negedge clk);
        hif_a.start = 1'b0; b2b_mode = 1'b0;
        check("b2b second acceptance", a_nrise, n + 2);
        wait_a(3);
        repeat (3) @(negedge clk);

        // Reset after the 5th wrx pulse
        preload_a(12'h5A5);
        hif_a.tx_data = 12'hFFF; hif_a.start = 1'b1;
        @(negedge clk);
        hif_a.start = 1'b0;
        for (int i = 0; i < 200 && !(a_pulses == 5 && !wrx_a); i++) @(negedge clk);
        check("pulses before abort", a_pulses, 5);
        #2 nrst = 1'b0;
        #1;
        check("abort wrx", {31'd0, wrx_a}, 0);
        check("abort xin_shift", {31'd0, xin_shift_a}, 0);
        check("abort busy", {31'd0, hif_a.busy}, 0);
        check("abort nxin", {31'd0, nxin_a}, 1);
        check("abort done", {31'd0, hif_a.done}, 0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        repeat (60) @(negedge clk);
        preload_a(12'h777);
        go_a(12'h248, 12'h777);
        wait_a(4);
        repeat (2) @(negedge clk);

        // Random pairs exercise the strobe/data stability checks
        for (int k = 0; k < 50; k++) begin
            logic [11:0] xv, tv;
            xv = 12'($urandom); tv = 12'($urandom);
            preload_a(xv);
            go_a(tv, xv);
            wait_a(5 + k);
            @(negedge clk);
        end

        // Narrow configuration
        pre_val_b = 4'b0110; pre_b = 1'b1;
        repeat (2) @(negedge clk);
        pre_b = 1'b0;
        exp_b.push_back('{rx: 12'h006, x: 12'h009});
        hif_b.tx_data = 4'b1001; hif_b.start = 1'b1;
        @(negedge clk);
        hif_b.start = 1'b0; hif_b.tx_data = 4'b0000;
        for (int i = 0; i < 100 && b_ndone < 1; i++) @(negedge clk);
        check("b transfer completed", b_ndone, 1);
        repeat (3) @(negedge clk);

        check("a scoreboard drained", exp_a.size(), 0);
        check("b scoreboard drained", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/q2_xshift_port.md
Name: q2_xshift_port

Overview:
- Serial I/O engine at the far end of the bit-slice X-register chain.
- Acts as initiator of the slice shift protocol: holds `xin_shift`, pulses `wrx` once per bit, and drives `nxin` into slice 0.
- Acts as receiver of the open-drain `io` line from the most-significant slice, reassembling the word shifted out.
- A single transfer loads a new word into X and captures the old X contents.

Parameters:
- WIDTH, 12, number of slices in the chain and bits per transfer.
- SETTLE, 2, clk cycles to hold before each sample, allowing slice nets to settle (must be ≥ 1).
- STROBE_LEN, 1, clk cycles `wrx` is held high per bit (must be ≥ 1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- start  input  1  request a transfer; sampled only in IDLE.
- tx_data  input  WIDTH  word to load into X; captured when start is accepted.
- busy  output  1  high from the cycle after acceptance through the DONE cycle.
- done  output  1  one-cycle pulse when the transfer completes.
- rx_data  output  WIDTH  previous X contents; valid from done until the next acceptance.
- io_in  input  1  resolved io line of slice WIDTH-1 (pull-up high; low means that slice's X bit = 0).
- xin_shift  output  1  X mux select to slice chain.
- wrx  output  1  X register clock strobe to all slices.
- nxin  output  1  inverted serial input to slice 0.

Behaviour:
- Reset (async, nrst=0) forces:
  - state to IDLE; busy=0, done=0.
  - xin_shift=0, wrx=0, nxin=1.
  - rx_data=0; bit counter=0; tx shift register=0.
  - Reset mid-transfer aborts immediately. X in the slices may hold a partially shifted word; the port does not recover it.
- States: IDLE, SETUP, SAMPLE, STROBE, HOLD, DONE.
- IDLE, start=1 → SETUP:
  - tx_data is latched into the tx shift register.
  - bit count is cleared.
  - xin_shift rises and stays high through the last HOLD.
- SETUP: stay SETTLE cycles → SAMPLE.
- SAMPLE (1 cycle):
  - rx shift register shifts left, taking io_in into bit 0.
  - nxin is driven to ~tx_sr[WIDTH-1], then stays stable through STROBE and HOLD.
  - → STROBE.
- STROBE: wrx=1 for STROBE_LEN cycles. Every slice loads its lower neighbour's X; slice 0 loads ~nxin. → HOLD.
- HOLD:
  - tx_sr shifts left, bit count increments.
  - stay SETTLE cycles.
  - if count == WIDTH → DONE, else → SAMPLE.
- DONE (1 cycle):
  - done=1, rx_data updated from the rx shift register.
  - xin_shift=0, nxin=1.
  - → IDLE.
- Bit order:
  - MSB first both ways: the first io_in sample becomes rx_data[WIDTH-1], and tx_data[WIDTH-1] is the first bit shifted in.
  - After completion X holds tx_data exactly.
- Timing:
  - start accepted at cycle 0 gives done at cycle 1+SETTLE+WIDTH*(1+STROBE_LEN+SETTLE).
  - Defaults give done at cycle 51.
- busy is registered: 0 in IDLE, 1 in all other states.
- Ignored start: start while busy, including the DONE cycle. start is accepted at the earliest in the cycle after DONE.
- Output timing: wrx and nxin are register outputs (glitch-free). wrx is never high in the same cycle that nxin changes.
- Edge cases:
  - io_in is used only during SAMPLE.
  - tx_data changes after acceptance have no effect.
  - WIDTH=1 is legal: one sample, one strobe.

Test Plan:
- Reset values: nrst low then high → all outputs at reset values; no wrx pulses for 100 cycles with start=0.
- Basic swap (defaults): X chain model preloaded 12'hA5C, tx_data=12'h3F1, start one cycle → exactly 12 wrx pulses; done at cycle 51; rx_data=12'hA5C; model X=12'h3F1; busy low the cycle after done.
- Ignored start: start held high continuously → back-to-back transfers separated by exactly one IDLE cycle; pulses during busy ignored. Second transfer with tx_data=12'h000 returns rx_data=12'h3F1.
- Reset mid-transfer: nrst low after the 5th wrx pulse → wrx, xin_shift, busy drop asynchronously, nxin=1; no done. A new start then completes a normal 51-cycle transfer.
- Parameter sweep: WIDTH=4, SETTLE=1, STROBE_LEN=3 with tx=4'b1001, X=4'b0110 → done at cycle 22; rx=4'b0110; each wrx high exactly 3 cycles.
- Strobe/data stability: checker asserts nxin never changes while wrx=1, and xin_shift is high during every wrx pulse, across 50 random tx/X pairs.
